xps2_rx_fifo: RTL and testbench
===============================

# xps2_rx_fifo

Parametrised PS/2 keyboard receiver for the calculator's controller data bus, mapped at `PS2_BASE` (data) and `PS2_BASE+1` (status/control). It replaces the bare PS/2 shift register with four additions: a filtered clock-edge detector, a frame state machine with parity, start and stop checking, a FIFO of configurable depth, and a status word. The status word provides the "done" flag and the software reset the top level needs. Reads are combinational so the top-level address decoder can return `data_out` in the same cycle.

## Interface
Parameters:
- `DATA_W`, 32: controller data bus width.
- `FIFO_DEPTH`, 8: received-byte FIFO depth; must be a power of two, at least 2.
- `FILT_LEN`, 4: consecutive equal samples required to accept a new `PS2_CLK` level.
- `TIMEOUT_CYC`, 100000: number of idle `clk` cycles inside a frame before the frame is aborted.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `PS2_CLK`  in  1  raw PS/2 clock pin (asynchronous).
- `PS2_DATA`  in  1  raw PS/2 data pin (asynchronous).
- `sel`  in  1  controller data select for this block.
- `we`  in  1  write enable.
- `addr`  in  1  0 = data register, 1 = status/control register.
- `data_in`  in  `DATA_W`  write data.
- `data_out`  out  `DATA_W`  read data (combinational).
- `irq`  out  1  high while the FIFO is not empty.

## Operation
- Both pins pass through a 2-flop synchroniser. The synchronised clock feeds the `FILT_LEN` filter. A filtered 1→0 transition produces a single-cycle `fall` pulse.
- The frame FSM samples the synchronised `PS2_DATA` on each `fall`:
  - IDLE: if the sampled bit is 0, go to DATA with bit counter = 0. If it is 1, stay in IDLE and do not set `frame_err`.
  - DATA: shift bits in LSB first. After the 8th bit, go to PARITY.
  - PARITY: store the bit, then go to STOP.
  - STOP: return to IDLE. If stop = 1 and parity is odd over the 9 bits, push the byte. If stop = 0, set `frame_err`. If parity fails, set `parity_err`. No push occurs on either error.
- FIFO:
  - A push while full drops the byte and sets sticky `overflow`.
  - A push and a pop in the same cycle are both honoured, including when full (no overflow) and when empty (the pop is ignored and the push proceeds).
- Read at `addr` 0 returns `{valid, 23'b0, head_byte}`, with `valid` in bit `DATA_W-1`. If the FIFO is empty it returns `valid` = 0 and byte = 0. A read strobe (`sel & ~we & addr==0`) pops the FIFO when it is not empty.
- Read at `addr` 1 returns the status word:
  - bit 0: not_empty
  - bit 1: full
  - bit 2: overflow
  - bit 3: parity_err
  - bit 4: frame_err
  - bits [15:8]: count
  - all other bits: 0
- Write at `addr` 1:
  - bits 2–4 are write-1-to-clear for the matching flags.
  - bit 31 = 1 flushes the FIFO, returns the FSM to IDLE and clears the bit counter. The flags are kept.
- Writes to `addr` 0 are ignored.

## Timing
- Reset values: `data_out` reflects the empty state (status = 0, data = 0). `irq` = 0. FSM is IDLE. FIFO is empty. All flags are 0. Filter state is 1. Reset acts immediately, including mid-frame.
- Latency from a `PS2_CLK` pin falling edge to the `fall` pulse is 2 + `FILT_LEN` cycles, ±1 cycle.
- A valid byte is visible at `addr` 0 and `irq` rises on the cycle after the STOP-bit `fall`.
- A pop takes effect at the clock edge ending the read cycle. The next head byte is visible on the following cycle.
- Flush takes priority over a push in the same cycle. A W1C clear and a new error event in the same cycle leave the flag set.
- `count` saturates at `FIFO_DEPTH`. FIFO pointers wrap modulo `FIFO_DEPTH`.

## Configuration
- `PS2_TIMEOUT_EN` defined: a counter clears on every `fall` and runs while the FSM is not IDLE. On reaching `TIMEOUT_CYC` the FSM returns to IDLE, `frame_err` is set, and the partial byte is discarded.
- `PS2_TIMEOUT_EN` undefined: there is no counter. The FSM waits indefinitely for the remaining edges, and `frame_err` is set only by a bad stop bit.

## Test plan
- Reset, then send frame 0x1C with odd parity bit 0 → status reads 0x0000_0101, `irq` = 1, data read returns 0x8000_001C. The following status read returns 0.
- Send 9 good frames 0x01..0x09 with `FIFO_DEPTH` = 8 → status has full = 1, overflow = 1, count = 8. Eight reads return 0x01..0x08, then a read returns 0x0000_0000.
- Send 0x5A with a wrong parity bit → no push, status = 0x0000_0008. Write 0x8 to `addr` 1 → status = 0.
- Send a frame with stop bit = 0 → frame_err set, no push. With `PS2_TIMEOUT_EN`, stop the clock after 4 data bits → frame_err set after `TIMEOUT_CYC` cycles, and a subsequent good 0x33 frame is received correctly.
- With 3 bytes queued, write 0x8000_0000 to `addr` 1 mid-frame → count = 0, `irq` = 0, FSM in IDLE. The next full frame 0x45 is received correctly.
- Assert `rst` low during DATA with 2 bytes queued → all outputs return to their reset values immediately. After release, frame 0x29 is received correctly.

Source files
------------

// File: rtl/xps2_rx_fifo.sv
// PS/2 keyboard receiver: synchronised + filtered clock, framed byte checker, byte FIFO and
// status/control word. Define PS2_TIMEOUT_EN to abort frames that stall for TIMEOUT_CYC cycles.
module xps2_rx_fifo #(
  parameter int DATA_W      = 32,
  parameter int FIFO_DEPTH  = 8,
  parameter int FILT_LEN    = 4,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              PS2_CLK,
  input  logic              PS2_DATA,
  input  logic              sel,
  input  logic              we,
  input  logic              addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              irq
);
  localparam int AW        = $clog2(FIFO_DEPTH);
  localparam int CW        = AW + 1;
  localparam int FW        = $clog2(FILT_LEN + 1);
  localparam int FLUSH_BIT = (DATA_W > 31) ? 31 : DATA_W - 1;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic [1:0]    clk_sync_q, clk_sync_d;
  logic [1:0]    dat_sync_q, dat_sync_d;
  logic          filt_q, filt_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic          fall_q, fall_d;

  state_t        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          par_err_q, par_err_d;
  logic          frm_err_q, frm_err_d;

  logic [7:0]    fifo_mem [FIFO_DEPTH];

  logic          dat_bit;
  logic          rd_data, wr_ctrl, flush;
  logic [2:0]    clr;
  logic          push, push_ok, pop_ok, ovf_ev, par_ev, frame_ev;
  logic          full, not_empty;
  logic          unused_wr;

  assign dat_bit   = dat_sync_q[1];
  assign rd_data   = sel & ~we & ~addr;
  assign wr_ctrl   = sel & we & addr;
  assign flush     = wr_ctrl & data_in[FLUSH_BIT];
  assign clr       = wr_ctrl ? data_in[4:2] : 3'b000;
  assign unused_wr = ^data_in;

  assign full      = (count_q == CW'(FIFO_DEPTH));
  assign not_empty = (count_q != '0);
  assign irq       = not_empty;

  // Two-flop synchronisers, then a level filter that only accepts a new clock level
  // after FILT_LEN consecutive samples disagree with the current one.
  always_comb begin
    clk_sync_d = {clk_sync_q[0], PS2_CLK};
    dat_sync_d = {dat_sync_q[0], PS2_DATA};
    filt_d     = filt_q;
    filt_cnt_d = '0;
    fall_d     = 1'b0;
    if (clk_sync_q[1] != filt_q) begin
      if (filt_cnt_q == FW'(FILT_LEN - 1)) begin
        filt_d = clk_sync_q[1];
        fall_d = filt_q;
      end else begin
        filt_cnt_d = filt_cnt_q + FW'(1);
      end
    end
  end

`ifdef PS2_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] to_cnt_q, to_cnt_d;
`endif

  // Frame state machine; all transitions happen on a filtered falling edge
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    push      = 1'b0;
    frame_ev  = 1'b0;
    par_ev    = 1'b0;
    if (fall_q) begin
      unique case (state_q)
        S_IDLE: begin
          if (!dat_bit) begin
            state_d   = S_DATA;
            bit_cnt_d = '0;
          end
        end
        S_DATA: begin
          shift_d   = {dat_bit, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
          par_d   = dat_bit;
          state_d = S_STOP;
        end
        S_STOP: begin
          state_d  = S_IDLE;
          frame_ev = ~dat_bit;
          par_ev   = ~(^{shift_q, par_q});
          push     = dat_bit & (^{shift_q, par_q});
        end
        default: state_d = S_IDLE;
      endcase
    end
`ifdef PS2_TIMEOUT_EN
    to_cnt_d = to_cnt_q;
    if (fall_q || state_q == S_IDLE) begin
      to_cnt_d = '0;
    end else if (to_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
      to_cnt_d = '0;
      state_d  = S_IDLE;
      frame_ev = 1'b1;
    end else begin
      to_cnt_d = to_cnt_q + TW'(1);
    end
    if (flush) to_cnt_d = '0;
`endif
    if (flush) begin
      state_d   = S_IDLE;
      bit_cnt_d = '0;
      push      = 1'b0;
    end
  end

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
  assign pop_ok  = rd_data & not_empty;
  assign push_ok = push & (~full | pop_ok);
  assign ovf_ev  = push & full & ~pop_ok;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
    // A new event wins over a simultaneous write-1-to-clear
    ovf_d     = (ovf_q     & ~clr[0]) | ovf_ev;
    par_err_d = (par_err_q & ~clr[1]) | par_ev;
    frm_err_d = (frm_err_q & ~clr[2]) | frame_ev;
  end

  always_comb begin
    data_out = '0;
    if (addr) begin
      data_out[0]    = not_empty;
      data_out[1]    = full;
      data_out[2]    = ovf_q;
      data_out[3]    = par_err_q;
      data_out[4]    = frm_err_q;
      data_out[15:8] = 8'(count_q);
    end else if (not_empty) begin
      data_out[DATA_W-1] = 1'b1;
      data_out[7:0]      = fifo_mem[rd_ptr_q];
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr_q] <= shift_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      filt_q     <= 1'b1;
      filt_cnt_q <= '0;
      fall_q     <= 1'b0;
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      par_err_q  <= 1'b0;
      frm_err_q  <= 1'b0;
    end else begin
      clk_sync_q <= clk_sync_d;
      dat_sync_q <= dat_sync_d;
      filt_q     <= filt_d;
      filt_cnt_q <= filt_cnt_d;
      fall_q     <= fall_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      par_err_q  <= par_err_d;
      frm_err_q  <= frm_err_d;
    end
  end

`ifdef PS2_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) to_cnt_q <= '0;
    else      to_cnt_q <= to_cnt_d;
  end
`endif

endmodule

// File: tb/tb_xps2_rx_fifo.sv
// Self-checking bench for xps2_rx_fifo: table of single frames, hand-written corner sequences,
// and randomized frames/reads checked against a queue-based reference model.
module tb_xps2_rx_fifo;
  localparam int DATA_W      = 32;
  localparam int DEPTH       = 8;
  localparam int FILT_LEN    = 4;
  localparam int TIMEOUT_CYC = 2000;
  localparam int HALF        = 20;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              PS2_CLK = 1'b1;
  logic              PS2_DATA = 1'b1;
  logic              sel = 1'b0;
  logic              we = 1'b0;
  logic              addr = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic [DATA_W-1:0] data_out;
  logic              irq;

  xps2_rx_fifo #(
    .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH), .FILT_LEN(FILT_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst(rst), .PS2_CLK(PS2_CLK), .PS2_DATA(PS2_DATA),
    .sel(sel), .we(we), .addr(addr), .data_in(data_in),
    .data_out(data_out), .irq(irq)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_fall_cyc = 0;
  int irq_rise_cyc = 0;
  int waited = 0;
  bit stop_fell = 1'b0;
  logic irq_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (irq && !irq_prev) irq_rise_cyc <= cyc;
    irq_prev <= irq;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  logic [7:0] mq[$];
  bit m_ovf, m_par, m_frm;

  function automatic void m_reset();
    mq.delete();
    m_ovf = 0; m_par = 0; m_frm = 0;
  endfunction

  function automatic void m_frame(input logic [7:0] b, input bit pgood, input bit stop);
    if (stop && pgood) begin
      if (mq.size() < DEPTH) mq.push_back(b);
      else m_ovf = 1;
    end
    if (!stop)  m_frm = 1;
    if (!pgood) m_par = 1;
  endfunction

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s = '0;
    s[0] = (mq.size() != 0);
    s[1] = (mq.size() == DEPTH);
    s[2] = m_ovf;
    s[3] = m_par;
    s[4] = m_frm;
    s[15:8] = 8'(mq.size());
    return s;
  endfunction

  function automatic logic [31:0] m_read();
    logic [31:0] r;
    r = '0;
    if (mq.size() != 0) begin
      r[31] = 1'b1;
      r[7:0] = mq.pop_front();
    end
    return r;
  endfunction

  function automatic void m_clear(input logic [2:0] c);
    if (c[0]) m_ovf = 0;
    if (c[1]) m_par = 0;
    if (c[2]) m_frm = 0;
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h", name, got, exp);
    end else begin
      $display("  %s: %08h ok", name, got);
    end
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] b, input bit pgood, input bit stop);
    logic par;
    par = pgood ? ~(^b) : (^b);
    return {stop, par, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int n);
    stop_fell = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      PS2_DATA = bits[i];
      repeat (HALF) @(negedge clk);
      PS2_CLK = 1'b0;
      last_fall_cyc = cyc;
      if (i == 10) stop_fell = 1;
      repeat (HALF) @(negedge clk);
      PS2_CLK = 1'b1;
    end
    @(negedge clk);
    PS2_DATA = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit pgood, input bit stop);
    send_bits(make_frame(b, pgood, stop), 11);
  endtask

  task automatic bus_read(input logic a, output logic [31:0] d);
    @(negedge clk);
    sel = 1'b1; we = 1'b0; addr = a;
    #1 d = data_out;
    @(negedge clk);
    sel = 1'b0; addr = 1'b0;
  endtask

  task automatic bus_write(input logic a, input logic [31:0] w);
    @(negedge clk);
    sel = 1'b1; we = 1'b1; addr = a; data_in = w;
    @(negedge clk);
    sel = 1'b0; we = 1'b0; addr = 1'b0; data_in = '0;
  endtask

  typedef struct {
    logic [7:0]  b;
    bit          pgood;
    bit          stop;
    logic [31:0] exp_stat;
    logic [31:0] exp_data;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [31:0] d, e, w;
    int lat, nr;
    logic [7:0] rb;
    bit pg, st;

    tbl[0] = '{8'h1C, 1'b1, 1'b1, 32'h0000_0101, 32'h8000_001C};
    tbl[1] = '{8'h5A, 1'b0, 1'b1, 32'h0000_0008, 32'h0000_0000};
    tbl[2] = '{8'h77, 1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000};
    tbl[3] = '{8'hFF, 1'b1, 1'b1, 32'h0000_0101, 32'h8000_00FF};
    tbl[4] = '{8'h00, 1'b1, 1'b1, 32'h0000_0101, 32'h8000_0000};
    tbl[5] = '{8'hA5, 1'b0, 1'b0, 32'h0000_0018, 32'h0000_0000};

    m_reset();
    repeat (3) @(negedge clk);
    #1;
    check("rst_irq", {31'b0, irq}, 32'h0);
    check("rst_data", data_out, 32'h0);
    addr = 1'b1;
    #1 check("rst_stat", data_out, 32'h0);
    addr = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // single frames from an empty FIFO
    for (int i = 0; i < 6; i++) begin
      send_frame(tbl[i].b, tbl[i].pgood, tbl[i].stop);
      m_frame(tbl[i].b, tbl[i].pgood, tbl[i].stop);
      check("tbl_irq", {31'b0, irq}, {31'b0, tbl[i].exp_data[31]});
      if (tbl[i].exp_data[31]) begin
        lat = irq_rise_cyc - last_fall_cyc;
        vectors++;
        if (lat < 2 + FILT_LEN || lat > 4 + FILT_LEN) begin
          miscompares++;
          $display("FAIL tbl_irq_latency: got %0d cycles required %0d..%0d", lat, 2 + FILT_LEN, 4 + FILT_LEN);
        end else begin
          $display("  tbl_irq_latency: %0d cycles ok", lat);
        end
      end
      bus_read(1'b1, d);
      check("tbl_stat", d, tbl[i].exp_stat);
      bus_read(1'b0, d);
      check("tbl_data", d, tbl[i].exp_data);
      e = m_read();
      bus_write(1'b1, 32'h0000_001C);
      m_clear(3'b111);
      bus_read(1'b1, d);
      check("tbl_stat_clr", d, 32'h0);
    end

    // nine frames into an eight-deep FIFO
    for (int i = 1; i <= 9; i++) begin
      send_frame(8'(i), 1'b1, 1'b1);
      m_frame(8'(i), 1'b1, 1'b1);
    end
    bus_read(1'b1, d);
    check("ovf_stat", d, 32'h0000_0807);
    for (int i = 0; i < 9; i++) begin
      bus_read(1'b0, d);
      e = m_read();
      check("ovf_data", d, e);
    end
    bus_write(1'b1, 32'h0000_0004);
    m_clear(3'b001);
    bus_read(1'b1, d);
    check("ovf_clr", d, 32'h0);

    // push into a full FIFO in the same cycle as a pop
    for (int i = 0; i < 8; i++) begin
      send_frame(8'h11 + 8'(i), 1'b1, 1'b1);
      m_frame(8'h11 + 8'(i), 1'b1, 1'b1);
    end
    bus_read(1'b1, d);
    check("full_stat", d, 32'h0000_0803);
    fork
      send_frame(8'h19, 1'b1, 1'b1);
      begin
        waited = 0;
        while (!stop_fell && waited < 2000) begin
          @(negedge clk);
          waited++;
        end
        if (!stop_fell) begin
          vectors++;
          miscompares++;
          $display("FAIL same_cycle_wait: got no stop edge required one within 2000 cycles");
        end else begin
          while (cyc < last_fall_cyc + 2 + FILT_LEN) @(negedge clk);
          sel = 1'b1; we = 1'b0; addr = 1'b0;
          #1 d = data_out;
          @(negedge clk);
          sel = 1'b0;
          e = m_read();
          check("same_cycle_pop", d, e);
        end
      end
    join
    m_frame(8'h19, 1'b1, 1'b1);
    bus_read(1'b1, d);
    check("same_cycle_stat", d, m_status());
    for (int i = 0; i < 8; i++) begin
      bus_read(1'b0, d);
      e = m_read();
      check("same_cycle_drain", d, e);
    end

    // flush mid-frame with three bytes queued
    for (int i = 0; i < 3; i++) begin
      send_frame(8'hC0 + 8'(i), 1'b1, 1'b1);
      m_frame(8'hC0 + 8'(i), 1'b1, 1'b1);
    end
    send_bits(make_frame(8'h45, 1'b1, 1'b1), 4);
    bus_write(1'b1, 32'h8000_0000);
    mq.delete();
    #1 check("flush_irq", {31'b0, irq}, 32'h0);
    bus_read(1'b1, d);
    check("flush_count", {24'b0, d[15:8]}, 32'h0);
    check("flush_stat", d, m_status());
    send_frame(8'h45, 1'b1, 1'b1);
    m_frame(8'h45, 1'b1, 1'b1);
    bus_read(1'b0, d);
    check("flush_next", d, 32'h8000_0045);
    e = m_read();

    // reset mid-frame with two bytes queued
    send_frame(8'h11, 1'b1, 1'b1);
    send_frame(8'h22, 1'b1, 1'b1);
    send_bits(make_frame(8'h5C, 1'b1, 1'b1), 3);
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    #1 check("midrst_irq", {31'b0, irq}, 32'h0);
    check("midrst_data", data_out, 32'h0);
    addr = 1'b1;
    #1 check("midrst_stat", data_out, 32'h0);
    addr = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    send_frame(8'h29, 1'b1, 1'b1);
    bus_read(1'b0, d);
    check("midrst_next", d, 32'h8000_0029);

`ifdef PS2_TIMEOUT_EN
    // stalled frame is aborted after the timeout
    send_bits(make_frame(8'h3C, 1'b1, 1'b1), 5);
    repeat (TIMEOUT_CYC - 200) @(negedge clk);
    bus_read(1'b1, d);
    check("timeout_early", d, 32'h0);
    repeat (300) @(negedge clk);
    bus_read(1'b1, d);
    check("timeout_stat", d, 32'h0000_0010);
    bus_write(1'b1, 32'h0000_0010);
    send_frame(8'h33, 1'b1, 1'b1);
    bus_read(1'b0, d);
    check("timeout_next", d, 32'h8000_0033);
`endif

    // randomized frames, reads, clears and ignored data-register writes
    for (int i = 0; i < 20; i++) begin
      rb = 8'($urandom_range(0, 255));
      pg = ($urandom_range(0, 9) != 0);
      st = ($urandom_range(0, 9) != 0);
      send_frame(rb, pg, st);
      m_frame(rb, pg, st);
      bus_read(1'b1, d);
      check("rnd_stat", d, m_status());
      nr = $urandom_range(0, 2);
      for (int j = 0; j < nr; j++) begin
        bus_read(1'b0, d);
        e = m_read();
        check("rnd_data", d, e);
      end
      if ($urandom_range(0, 3) == 0) begin
        w = $urandom;
        w[31] = 1'b0;
        bus_write(1'b1, w);
        m_clear(w[4:2]);
      end
      if ($urandom_range(0, 4) == 0) bus_write(1'b0, $urandom);
    end
    for (int j = 0; j < DEPTH + 1; j++) begin
      bus_read(1'b0, d);
      e = m_read();
      check("rnd_drain", d, e);
    end
    bus_read(1'b1, d);
    check("rnd_final_stat", d, m_status());

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
